mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Sole owner of the byte-serial unified RAM/IO port.
- Arbitrates between the LSB (loads, committed stores) and instruction fetch, then serialises each access into 1/2/4 byte beats.
- Reassembles load data with sign or zero extension and returns one-cycle success pulses to the LSB and fetch unit.
- Sits directly downstream of the LSB: it consumes the LSB's read/write requests and produces its load/store completions.

Parameters:
- IO_SEL, 2'b11: value of addr[17:16] that marks an IO address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- jump_wrong  in  1  misprediction flush
- lsb_read_signal  in  1  LSB load request (level, held until success)
- lsb_write_signal  in  1  LSB committed-store request (level)
- requiring_length  in  2  0 = byte, 1 = half, 2 = word
- to_mem_addr  in  32  LSB byte address
- to_mem_data  in  32  store data, low bytes used
- load_signed  in  1  1 = sign-extend load, 0 = zero-extend
- mem_load_success  out  1  one-cycle load-done pulse
- mem_store_success  out  1  one-cycle store-done pulse
- from_mem_data  out  32  extended load result, valid with mem_load_success
- if_read_signal  in  1  fetch request (level)
- if_addr  in  32  fetch address
- if_success  out  1  one-cycle fetch-done pulse
- if_instr  out  32  fetched word, valid with if_success
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  IO write buffer full

Behaviour:
- **Reset** (synchronous, rst=1 at posedge):
  - State = IDLE, beat counter = 0.
  - All outputs 0: success pulses, from_mem_data, if_instr, mem_a, mem_dout, mem_wr.
  - Reset wins over every other input, including mid-transfer; no partial completion is reported.
- **rdy=0:** no state, counter, or output register changes, except mem_wr, which is forced 0.
- **States:** IDLE, LOAD, STORE, FETCH.
- **IDLE priority** (sampled at each posedge):
  1. lsb_write_signal → STORE
  2. lsb_read_signal → LOAD
  3. if_read_signal → FETCH
  - The request's address, data, length (FETCH = 4 bytes) and signedness are latched at acceptance.
  - The LSB is favoured to avoid fetch starving commits.
- **No back-to-back acceptance:** the edge that emits a success pulse moves to IDLE. A new request is accepted no earlier than the following edge, so a level request dropped in response to the pulse is never re-accepted.
- **Timing:** the acceptance edge ends cycle 0; n = byte count.
- **RAM read latency is 1:** mem_a driven in cycle c gives mem_din valid in cycle c+1.
- **LOAD / FETCH:**
  - mem_a = addr+k, mem_wr=0 in cycles 1..n.
  - Byte k is captured from mem_din in cycle k+2 and placed in bits [8k+7:8k] (little-endian).
  - The success pulse and data register are valid in cycle n+2. Word: pulse in cycle 6.
- **Load extension:**
  - Byte: bit 7 replicated into [31:8] if signed, else zeros.
  - Half: bit 15 replicated into [31:16] if signed, else zeros.
  - Word: unchanged.
- **STORE:**
  - mem_a = addr+k, mem_dout = data byte k, mem_wr=1 in cycles 1..n.
  - mem_store_success pulses in cycle n+1.
- **IO stall:** if addr[17:16]==IO_SEL and io_buffer_full=1 during a STORE beat, that beat is not issued (mem_wr=0) and the counter holds until io_buffer_full=0.
- **Address arithmetic:** addr+k is 32-bit, wrapping modulo 2^32.
- **Idle outputs:** outside active beats mem_wr=0, mem_a=0, mem_dout=0.
- **jump_wrong=1 at a posedge:**
  - LOAD and FETCH abort to IDLE with no success pulse. The LSB and fetch have been flushed upstream.
  - STORE is never aborted: the store is already committed and completes normally.
  - A request visible in IDLE on the flush edge is not accepted.
- **Pulse widths:** success pulses are exactly one cycle; from_mem_data and if_instr hold their value until the next completion.

Test Plan:
- Word fetch: if_read_signal=1, if_addr=0x100, RAM bytes 13 05 10 00 → mem_a 0x100..0x103 in cycles 1-4; if_success=1 with if_instr=0x00100513 in cycle 6 only.
- Signed byte load: addr 0x200 holds 0x80, length 0, load_signed=1 → from_mem_data=0xFFFFFF80 with pulse in cycle 3; same with load_signed=0 → 0x00000080.
- Half store: to_mem_data=0xDEADBEEF, addr 0x300, length 1 → mem_wr=1 with (0x300,0xEF) in cycle 1 and (0x301,0xBE) in cycle 2; mem_store_success in cycle 3.
- Arbitration: lsb_write_signal, lsb_read_signal and if_read_signal all asserted in the same cycle → STORE first, then LOAD, then FETCH. Exactly one pulse per request; no duplicate acceptance of the held levels.
- IO stall: store byte 0x41 to 0x30000, io_buffer_full=1 for 3 cycles → mem_wr=0 for those 3 cycles, then one write beat, then mem_store_success.
- Flush and reset: jump_wrong=1 in cycle 3 of a word load → no mem_load_success, back to IDLE. jump_wrong=1 mid-store → store still completes. rst=1 mid-store → all outputs 0 the next cycle, no pulse.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrated byte-serial RAM/IO port controller for LSB loads/stores and instruction fetch
module mem_ctrl #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_wrong,
    input  logic        lsb_read_signal,
    input  logic        lsb_write_signal,
    input  logic [1:0]  requiring_length,
    input  logic [31:0] to_mem_addr,
    input  logic [31:0] to_mem_data,
    input  logic        load_signed,
    output logic        mem_load_success,
    output logic        mem_store_success,
    output logic [31:0] from_mem_data,
    input  logic        if_read_signal,
    input  logic [31:0] if_addr,
    output logic        if_success,
    output logic [31:0] if_instr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

    state_t      state, state_d;
    logic [2:0]  cyc, cyc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  len_q, len_d;
    logic        sgn_q, sgn_d;
    logic [31:0] asm_q, asm_d;
    logic        wr_q, wr_d;
    logic [31:0] a_d;
    logic [7:0]  dout_d;
    logic        ld_ok_d, st_ok_d, if_ok_d;
    logic [31:0] ld_data_d, instr_d;

    logic        io_stall;
    logic [2:0]  req_len;
    logic [1:0]  rd_idx;
    logic [1:0]  st_idx;
    logic [31:0] word_in;
    logic [31:0] ext_word;

    // A write beat to a full IO buffer is withheld; rdy low also suppresses the strobe.
    assign io_stall = (state == STORE) && (addr_q[17:16] == IO_SEL) && io_buffer_full;
    assign mem_wr   = wr_q & rdy & ~io_stall;

    assign req_len = (requiring_length == 2'd0) ? 3'd1 :
                     (requiring_length == 2'd1) ? 3'd2 : 3'd4;

    // Read byte landing at the end of cycle c belongs to beat c-2.
    assign rd_idx = cyc[1:0] - 2'd2;
    assign st_idx = cyc[1:0] + 2'd1;

    always_comb begin
        word_in = asm_q;
        word_in[{rd_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        ext_word = word_in;
        if (len_q == 3'd1) begin
            ext_word = {{24{sgn_q & word_in[7]}}, word_in[7:0]};
        end else if (len_q == 3'd2) begin
            ext_word = {{16{sgn_q & word_in[15]}}, word_in[15:0]};
        end
    end

    always_comb begin
        state_d   = state;
        cyc_d     = cyc;
        addr_d    = addr_q;
        data_d    = data_q;
        len_d     = len_q;
        sgn_d     = sgn_q;
        asm_d     = asm_q;
        wr_d      = 1'b0;
        a_d       = 32'd0;
        dout_d    = 8'd0;
        ld_ok_d   = 1'b0;
        st_ok_d   = 1'b0;
        if_ok_d   = 1'b0;
        ld_data_d = from_mem_data;
        instr_d   = if_instr;

        case (state)
            IDLE: begin
                if (!jump_wrong) begin
                    if (lsb_write_signal) begin
                        state_d = STORE;
                        addr_d  = to_mem_addr;
                        data_d  = to_mem_data;
                        len_d   = req_len;
                        cyc_d   = 3'd0;
                        a_d     = to_mem_addr;
                        dout_d  = to_mem_data[7:0];
                        wr_d    = 1'b1;
                    end else if (lsb_read_signal) begin
                        state_d = LOAD;
                        addr_d  = to_mem_addr;
                        len_d   = req_len;
                        sgn_d   = load_signed;
                        asm_d   = 32'd0;
                        cyc_d   = 3'd1;
                        a_d     = to_mem_addr;
                    end else if (if_read_signal) begin
                        state_d = FETCH;
                        addr_d  = if_addr;
                        len_d   = 3'd4;
                        sgn_d   = 1'b0;
                        asm_d   = 32'd0;
                        cyc_d   = 3'd1;
                        a_d     = if_addr;
                    end
                end
            end

            STORE: begin
                // Committed stores ignore jump_wrong and always run to completion.
                wr_d   = 1'b1;
                a_d    = mem_a;
                dout_d = mem_dout;
                if (!io_stall) begin
                    if (cyc == len_q - 3'd1) begin
                        state_d = IDLE;
                        wr_d    = 1'b0;
                        a_d     = 32'd0;
                        dout_d  = 8'd0;
                        st_ok_d = 1'b1;
                    end else begin
                        cyc_d  = cyc + 3'd1;
                        a_d    = addr_q + {30'd0, st_idx};
                        dout_d = data_q[{st_idx, 3'b000} +: 8];
                    end
                end
            end

            LOAD, FETCH: begin
                if (jump_wrong) begin
                    state_d = IDLE;
                end else begin
                    if (cyc >= 3'd2) begin
                        asm_d = word_in;
                    end
                    if (cyc == len_q + 3'd1) begin
                        state_d = IDLE;
                        if (state == LOAD) begin
                            ld_ok_d   = 1'b1;
                            ld_data_d = ext_word;
                        end else begin
                            if_ok_d = 1'b1;
                            instr_d = word_in;
                        end
                    end else begin
                        cyc_d = cyc + 3'd1;
                        if (cyc < len_q) begin
                            a_d = addr_q + {29'd0, cyc};
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cyc               <= 3'd0;
            addr_q            <= 32'd0;
            data_q            <= 32'd0;
            len_q             <= 3'd0;
            sgn_q             <= 1'b0;
            asm_q             <= 32'd0;
            wr_q              <= 1'b0;
            mem_a             <= 32'd0;
            mem_dout          <= 8'd0;
            mem_load_success  <= 1'b0;
            mem_store_success <= 1'b0;
            if_success        <= 1'b0;
            from_mem_data     <= 32'd0;
            if_instr          <= 32'd0;
        end else if (rdy) begin
            state             <= state_d;
            cyc               <= cyc_d;
            addr_q            <= addr_d;
            data_q            <= data_d;
            len_q             <= len_d;
            sgn_q             <= sgn_d;
            asm_q             <= asm_d;
            wr_q              <= wr_d;
            mem_a             <= a_d;
            mem_dout          <= dout_d;
            mem_load_success  <= ld_ok_d;
            mem_store_success <= st_ok_d;
            if_success        <= if_ok_d;
            from_mem_data     <= ld_data_d;
            if_instr          <= instr_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a byte-array reference model
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_wrong;
    logic        lsb_read_signal, lsb_write_signal;
    logic [1:0]  requiring_length;
    logic [31:0] to_mem_addr, to_mem_data;
    logic        load_signed;
    logic        mem_load_success, mem_store_success;
    logic [31:0] from_mem_data;
    logic        if_read_signal;
    logic [31:0] if_addr;
    logic        if_success;
    logic [31:0] if_instr;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .lsb_read_signal(lsb_read_signal), .lsb_write_signal(lsb_write_signal),
        .requiring_length(requiring_length), .to_mem_addr(to_mem_addr),
        .to_mem_data(to_mem_data), .load_signed(load_signed),
        .mem_load_success(mem_load_success), .mem_store_success(mem_store_success),
        .from_mem_data(from_mem_data), .if_read_signal(if_read_signal),
        .if_addr(if_addr), .if_success(if_success), .if_instr(if_instr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Device side: 64 KiB byte RAM (address bits [15:0]) with one cycle of read latency.
    logic [7:0] ram [0:65535];
    logic [7:0] ref_mem [0:65535];
    bit filled = 1'b0;

    function automatic logic [7:0] seed_byte(input int i);
        return 8'((i * 37) ^ (i >> 5) ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 65536; i++) ram[i] <= seed_byte(i);
            filled <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[15:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drop_all();
        lsb_read_signal  = 1'b0;
        lsb_write_signal = 1'b0;
        if_read_signal   = 1'b0;
    endtask

    task automatic drive_req(input int kind, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] lenc, input bit sgn);
        case (kind)
            0: begin lsb_write_signal = 1'b1; to_mem_addr = addr; to_mem_data = data; requiring_length = lenc; end
            1: begin lsb_read_signal = 1'b1; to_mem_addr = addr; requiring_length = lenc; load_signed = sgn; end
            default: begin if_read_signal = 1'b1; if_addr = addr; end
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n, input bit sgn);
        logic [31:0] raw;
        logic [31:0] a;
        raw = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            raw = raw | (32'(ref_mem[a[15:0]]) << (8 * k));
        end
        if (sgn && n < 4 && raw[8*n-1]) raw = raw | (32'hFFFF_FFFF << (8 * n));
        return raw;
    endfunction

    // kind: 0 store, 1 load, 2 fetch. flush_at = cycle with jump_wrong high (0 = none).
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] lenc, input bit sgn, input int flush_at,
                          input logic [31:0] stall_seq, input logic [31:0] rdy_seq,
                          output logic [31:0] result);
        int n, k;
        bit is_io, st, done, aborted, pulse;
        logic [31:0] a, exp_v;
        n = (kind == 2 || lenc >= 2'd2) ? 4 : (lenc == 2'd1 ? 2 : 1);
        is_io = (addr[17:16] == 2'b11);
        result = 32'd0;
        exp_v = model_read(addr, n, (kind == 1) && sgn);
        @(posedge clk); #1;
        drive_req(kind, addr, data, lenc, sgn);
        if (kind == 0) begin
            k = 0;
            done = 1'b0;
            for (int c = 1; c <= 40 && !done; c++) begin
                @(posedge clk); #1;
                io_buffer_full = (c <= 32) ? stall_seq[c-1] : 1'b0;
                rdy = (k < n && c <= 32) ? !rdy_seq[c-1] : 1'b1;
                jump_wrong = (c == flush_at);
                @(negedge clk);
                if (k < n) begin
                    st = (is_io && io_buffer_full) || !rdy;
                    a = addr + 32'(k);
                    check("st_wr", {31'd0, mem_wr}, {31'd0, !st});
                    check("st_addr", mem_a, a);
                    check("st_dout", {24'd0, mem_dout}, (data >> (8 * k)) & 32'hFF);
                    check("st_early_pulse", {31'd0, mem_store_success}, 32'd0);
                    if (!st) begin
                        ref_mem[a[15:0]] = 8'(data >> (8 * k));
                        k++;
                    end
                end else begin
                    check("st_pulse", {31'd0, mem_store_success}, 32'd1);
                    check("st_done_wr", {31'd0, mem_wr}, 32'd0);
                    check("st_done_addr", mem_a, 32'd0);
                    lsb_write_signal = 1'b0;
                    done = 1'b1;
                end
            end
            check("st_completed", {31'd0, done}, 32'd1);
            drop_all();
        end else begin
            aborted = 1'b0;
            for (int c = 1; c <= n + 2; c++) begin
                @(posedge clk); #1;
                jump_wrong = (c == flush_at);
                if (c == flush_at) drop_all();
                @(negedge clk);
                pulse = (kind == 1) ? mem_load_success : if_success;
                if (aborted) begin
                    check("flush_idle_addr", mem_a, 32'd0);
                    check("flush_no_pulse", {31'd0, pulse}, 32'd0);
                end else begin
                    check("rd_wr", {31'd0, mem_wr}, 32'd0);
                    check("rd_addr", mem_a, (c <= n) ? addr + 32'(c - 1) : 32'd0);
                    check("rd_pulse", {31'd0, pulse}, {31'd0, c == n + 2});
                    if (c == n + 2) begin
                        result = (kind == 1) ? from_mem_data : if_instr;
                        check(kind == 1 ? "load_data" : "fetch_data", result, exp_v);
                        drop_all();
                    end
                end
                if (c == flush_at) aborted = 1'b1;
            end
        end
        @(posedge clk); #1;
        jump_wrong = 1'b0;
        io_buffer_full = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        check("post_no_pulse", {29'd0, mem_store_success, mem_load_success, if_success}, 32'd0);
        check("post_idle_addr", mem_a, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, addr, data, exp_order[3];
        int seen, kind, n, extra;
        for (int i = 0; i < 65536; i++) ref_mem[i] = seed_byte(i);
        rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; io_buffer_full = 1'b0;
        drop_all();
        requiring_length = 2'd0; to_mem_addr = 32'd0; to_mem_data = 32'd0;
        load_signed = 1'b0; if_addr = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pulses", {29'd0, mem_store_success, mem_load_success, if_success}, 32'd0);
        check("reset_bus", {mem_a[23:0], mem_dout}, 32'd0);
        check("reset_wr", {31'd0, mem_wr}, 32'd0);
        check("reset_data", from_mem_data | if_instr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Word fetch of a known instruction
        do_txn(0, 32'h100, 32'h0010_0513, 2'd2, 1'b0, 0, 32'd0, 32'd0, r);
        do_txn(2, 32'h100, 32'd0, 2'd0, 1'b0, 0, 32'd0, 32'd0, r);
        check("fetch_const", r, 32'h0010_0513);

        // Signed and unsigned byte loads of 0x80
        do_txn(0, 32'h200, 32'h0000_0080, 2'd0, 1'b0, 0, 32'd0, 32'd0, r);
        do_txn(1, 32'h200, 32'd0, 2'd0, 1'b1, 0, 32'd0, 32'd0, r);
        check("lb_signed_const", r, 32'hFFFF_FF80);
        do_txn(1, 32'h200, 32'd0, 2'd0, 1'b0, 0, 32'd0, 32'd0, r);
        check("lb_unsigned_const", r, 32'h0000_0080);

        // Half store then signed half readback
        do_txn(0, 32'h300, 32'hDEAD_BEEF, 2'd1, 1'b0, 0, 32'd0, 32'd0, r);
        do_txn(1, 32'h300, 32'd0, 2'd1, 1'b1, 0, 32'd0, 32'd0, r);
        check("lh_signed_const", r, 32'hFFFF_BEEF);

        // IO store held off by a full buffer for three cycles
        do_txn(0, 32'h0003_0000, 32'h0000_0041, 2'd0, 1'b0, 0, 32'h7, 32'd0, r);

        // Flushes: load aborted in cycle 3, store unaffected
        do_txn(1, 32'h100, 32'd0, 2'd2, 1'b0, 3, 32'd0, 32'd0, r);
        do_txn(0, 32'h1010, 32'h1234_5678, 2'd2, 1'b0, 2, 32'd0, 32'd0, r);
        do_txn(1, 32'h1010, 32'd0, 2'd2, 1'b0, 0, 32'd0, 32'd0, r);
        check("store_after_flush", r, 32'h1234_5678);

        // Request visible in IDLE on a flush edge, and requests while rdy is low
        @(posedge clk); #1;
        jump_wrong = 1'b1;
        drive_req(1, 32'h1020, 32'd0, 2'd2, 1'b0);
        @(posedge clk); #1;
        jump_wrong = 1'b0;
        drop_all();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_flush_addr", mem_a, 32'd0);
            check("idle_flush_pulse", {31'd0, mem_load_success}, 32'd0);
            @(posedge clk); #1;
        end
        rdy = 1'b0;
        drive_req(0, 32'h1030, 32'hFFFF_FFFF, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rdy_low_addr", mem_a, 32'd0);
            check("rdy_low_wr", {31'd0, mem_wr}, 32'd0);
            @(posedge clk); #1;
        end
        drop_all();
        rdy = 1'b1;
        @(negedge clk);
        check("rdy_low_not_taken", mem_a, 32'd0);

        // Arbitration: store, then load of the same LSB address, then fetch
        for (int k = 0; k < 4; k++) ref_mem[16'h400 + 16'(k)] = 8'(32'hCAFE_F00D >> (8 * k));
        exp_order[0] = 32'd0; exp_order[1] = 32'd1; exp_order[2] = 32'd2;
        @(posedge clk); #1;
        drive_req(0, 32'h400, 32'hCAFE_F00D, 2'd2, 1'b1);
        drive_req(1, 32'h400, 32'd0, 2'd2, 1'b1);
        drive_req(2, 32'h600, 32'd0, 2'd0, 1'b0);
        seen = 0;
        extra = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            n = int'(mem_store_success) + int'(mem_load_success) + int'(if_success);
            if (n != 0) begin
                kind = mem_store_success ? 0 : (mem_load_success ? 1 : 2);
                if (seen < 3) begin
                    check("arb_order", 32'(kind), exp_order[seen]);
                    check("arb_single_pulse", 32'(n), 32'd1);
                    if (kind == 1) check("arb_load_data", from_mem_data, 32'hCAFE_F00D);
                    if (kind == 2) check("arb_fetch_data", if_instr, model_read(32'h600, 4, 1'b0));
                end else begin
                    extra++;
                end
                if (kind == 0) lsb_write_signal = 1'b0;
                else if (kind == 1) lsb_read_signal = 1'b0;
                else if_read_signal = 1'b0;
                seen++;
            end
        end
        check("arb_pulse_count", 32'(seen), 32'd3);
        check("arb_no_duplicates", 32'(extra), 32'd0);
        drop_all();

        // Randomized transactions against the reference byte array
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0, 1: addr = 32'h1000 + 32'($urandom_range(0, 63));
                2:    addr = 32'h0003_0000 + 32'($urandom_range(0, 15));
                default: addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            endcase
            data = $urandom;
            n = $urandom_range(0, 2);
            do_txn(kind, addr, data, 2'(n), 1'($urandom),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
                   $urandom & $urandom & 32'hFF,
                   $urandom & $urandom & $urandom & 32'hFF, r);
        end

        // Reset in the middle of a word store
        @(posedge clk); #1;
        drive_req(0, 32'h700, 32'hA5A5_5A5A, 2'd2, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drop_all();
        ref_mem[16'h700] = 8'h5A;
        ref_mem[16'h701] = 8'h5A;
        @(negedge clk);
        check("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mid_bus", mem_a | {24'd0, mem_dout}, 32'd0);
        check("rst_mid_data", from_mem_data | if_instr, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("rst_mid_no_pulse", {29'd0, mem_store_success, mem_load_success, if_success}, 32'd0);
            @(negedge clk);
        end
        do_txn(1, 32'h700, 32'd0, 2'd1, 1'b0, 0, 32'd0, 32'd0, r);
        check("rst_partial_store", r, 32'h0000_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
